joy_scan_ctrl: RTL and testbench



---
 rtl/joy_scan_pkg.sv | 35 +++
 rtl/joy_clk_gen.sv | 40 ++++
 rtl/joy_scan_ctrl.sv | 116 +++++++++++
 tb/tb_joy_scan_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/joy_scan_pkg.sv
// Shared types and constants for the serial joystick scanner.
// Covers the FSM state set, the slot numbering and the slot-to-bit mapping.
package joy_scan_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, SKIP, SHIFT, COMMIT} state_e;

  localparam logic [4:0] SLOT_LOAD  = 5'd0;
  localparam logic [4:0] SLOT_FIRST = 5'd2;
  localparam logic [4:0] SLOT_LAST  = 5'd25;

  typedef struct packed {
    logic       p2;    // 1 = player 2 word
    logic [3:0] bitn;
  } slot_map_t;

  // Slots 2..17 carry bits 8,6,5,4,3,2,1,0 per player; the tail carries 10,11,9,7.
  function automatic slot_map_t slot_map(input logic [4:0] slot);
    logic [4:0] idx;
    slot_map_t  m;
    idx  = slot - SLOT_FIRST;
    m.p2 = (idx >= 5'd8) && (idx < 5'd20);
    if (idx < 5'd16) begin
      m.bitn = (idx[2:0] == 3'd0) ? 4'd8 : {1'b0, 3'd7 - idx[2:0]};
    end else begin
      case (idx[1:0])
        2'd0:    m.bitn = 4'd10;
        2'd1:    m.bitn = 4'd11;
        2'd2:    m.bitn = 4'd9;
        default: m.bitn = 4'd7;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/joy_clk_gen.sv
// Shift-clock divider: JOY_CLK level plus sample (rising) and wrap strobes.
// The counter is parked at zero while run_i is low.
module joy_clk_gen #(
  parameter int DIV_HALF = 27
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic joy_clk_o,
  output logic sample_stb_o,
  output logic wrap_stb_o
);

  localparam logic [8:0] HALF = 9'(DIV_HALF);
  localparam logic [8:0] LAST = 9'(2 * DIV_HALF - 1);

  logic [8:0] cnt_q, cnt_d;
  logic       clk_q, clk_d;

  always_comb begin
    cnt_d = 9'd0;
    if (run_i && (cnt_q != LAST)) cnt_d = cnt_q + 9'd1;
    clk_d = (cnt_d >= HALF);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 9'd0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

  assign joy_clk_o    = clk_q;
  assign sample_stb_o = run_i && (cnt_q == HALF - 9'd1);
  assign wrap_stb_o   = run_i && (cnt_q == LAST);

endmodule

// File: rtl/joy_scan_ctrl.sv
// Serial joystick scanner: load/skip/shift sequencing of a 24-bit frame,
// demux into two active-low words and optional two-frame agreement filter.
module joy_scan_ctrl
  import joy_scan_pkg::*;
#(
  parameter int DIV_HALF = 27,
  parameter bit DEBOUNCE = 1'b1
) (
  input  logic        clk12,
  input  logic        reset_n,
  input  logic        scan_en,
  input  logic        JOY_DATA,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic [11:0] joystick1,
  output logic [11:0] joystick2,
  output logic        frame_done
);

  state_e      state_q, state_d;
  logic [4:0]  slot_q, slot_d;
  logic [11:0] raw1_q, raw1_d, raw2_q, raw2_d;
  logic [11:0] prev1_q, prev2_q;
  logic [11:0] j1_q, j2_q;
  logic        load_q, done_q;
  logic        sample_stb, wrap_stb, commit, match;
  slot_map_t   map;

  joy_clk_gen #(.DIV_HALF(DIV_HALF)) u_clk_gen (
    .clk_i        (clk12),
    .rst_ni       (reset_n),
    .run_i        (state_q != IDLE),
    .joy_clk_o    (JOY_CLK),
    .sample_stb_o (sample_stb),
    .wrap_stb_o   (wrap_stb)
  );

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    raw1_d  = raw1_q;
    raw2_d  = raw2_q;
    map     = slot_map(slot_q);
    case (state_q)
      IDLE: if (scan_en) begin
        state_d = LOAD;
        slot_d  = SLOT_LOAD;
      end
      LOAD: if (wrap_stb) begin
        state_d = SKIP;
        slot_d  = slot_q + 5'd1;
      end
      SKIP: if (wrap_stb) begin
        state_d = SHIFT;
        slot_d  = SLOT_FIRST;
      end
      SHIFT: begin
        if (sample_stb) begin
          if (map.p2) raw2_d[map.bitn] = JOY_DATA;
          else        raw1_d[map.bitn] = JOY_DATA;
          if (slot_q == SLOT_LAST) state_d = COMMIT;
        end
        // scan_en is only consulted at the frame boundary
        if (wrap_stb) begin
          if (slot_q == SLOT_LAST) begin
            state_d = scan_en ? LOAD : IDLE;
            slot_d  = SLOT_LOAD;
          end else begin
            slot_d = slot_q + 5'd1;
          end
        end
      end
      COMMIT:  state_d = SHIFT;
      default: state_d = IDLE;
    endcase
  end

  assign commit = (state_q == COMMIT);
  assign match  = (raw1_q == prev1_q) && (raw2_q == prev2_q);

  always_ff @(posedge clk12 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      slot_q  <= SLOT_LOAD;
      raw1_q  <= 12'hFFF;
      raw2_q  <= 12'hFFF;
      prev1_q <= 12'hFFF;
      prev2_q <= 12'hFFF;
      j1_q    <= 12'hFFF;
      j2_q    <= 12'hFFF;
      load_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      raw1_q  <= raw1_d;
      raw2_q  <= raw2_d;
      load_q  <= (state_d != LOAD);
      done_q  <= commit;
      if (commit) begin
        prev1_q <= raw1_q;
        prev2_q <= raw2_q;
        if (!DEBOUNCE || match) begin
          j1_q <= raw1_q;
          j2_q <= raw2_q;
        end
      end
    end
  end

  assign JOY_LOAD   = load_q;
  assign joystick1  = j1_q;
  assign joystick2  = j2_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_joy_scan_ctrl.sv
// Bench for joy_scan_ctrl: two instances (fast unfiltered, slower filtered)
// driven frame by frame and compared cycle by cycle against a slot-level model.
module tb_joy_scan_ctrl;

  localparam logic [25:0] ONES = 26'h3FFFFFF;
  // Source slot of each output bit, index = bit number 0..11
  localparam int J1S [12] = '{9, 8, 7, 6, 5, 4, 3, 25, 2, 24, 22, 23};
  localparam int J2S [12] = '{17, 16, 15, 14, 13, 12, 11, 21, 10, 20, 18, 19};

  logic clk = 1'b0;
  logic rst_n;
  logic scan_a, scan_b, jd_a, jd_b;
  logic ck_a, ld_a, dn_a, ck_b, ld_b, dn_b;
  logic [11:0] j1_a, j2_a, j1_b, j2_b;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp1 [2];
  logic [11:0] exp2 [2];
  logic [23:0] prev_m [2];

  always #5 clk = ~clk;

  joy_scan_ctrl #(.DIV_HALF(2), .DEBOUNCE(1'b0)) dut_a (
    .clk12(clk), .reset_n(rst_n), .scan_en(scan_a), .JOY_DATA(jd_a),
    .JOY_CLK(ck_a), .JOY_LOAD(ld_a), .joystick1(j1_a), .joystick2(j2_a),
    .frame_done(dn_a)
  );

  joy_scan_ctrl #(.DIV_HALF(3), .DEBOUNCE(1'b1)) dut_b (
    .clk12(clk), .reset_n(rst_n), .scan_en(scan_b), .JOY_DATA(jd_b),
    .JOY_CLK(ck_b), .JOY_LOAD(ld_b), .joystick1(j1_b), .joystick2(j2_b),
    .frame_done(dn_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic void words(input logic [25:0] sb, output logic [11:0] w1,
                                output logic [11:0] w2);
    for (int b = 0; b < 12; b++) begin
      w1[b] = sb[J1S[b]];
      w2[b] = sb[J2S[b]];
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      exp1[i]   = 12'hFFF;
      exp2[i]   = 12'hFFF;
      prev_m[i] = 24'hFFFFFF;
    end
  endfunction

  task automatic idle_check(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk("idle_load_a", ld_a, 1'b1);
      chk("idle_clk_a", ck_a, 1'b0);
      chk("idle_done_a", dn_a, 1'b0);
      chk("idle_j1_a", j1_a, exp1[0]);
      chk("idle_j2_a", j2_a, exp2[0]);
      chk("idle_load_b", ld_b, 1'b1);
      chk("idle_clk_b", ck_b, 1'b0);
      chk("idle_done_b", dn_b, 1'b0);
      chk("idle_j1_b", j1_b, exp1[1]);
      chk("idle_j2_b", j2_b, exp2[1]);
    end
  endtask

  // sb[s] is the JOY_DATA level presented during slot s. Entered one negedge
  // before the frame's first cycle; drop_slot / rst_slot < 0 means unused.
  task automatic run_frame(input int sel, input logic [25:0] sb,
                           input int drop_slot, input int rst_slot);
    int h, per, rises;
    logic pclk, take;
    logic [11:0] w1, w2, n1, n2, o1, o2;
    logic o_ld, o_ck, o_dn, other_ld;
    logic [11:0] o_j1, o_j2;
    h    = (sel == 1) ? 3 : 2;
    per  = 2 * h;
    words(sb, w1, w2);
    take = (sel == 0) || (sb[25:2] == prev_m[sel]);
    o1   = exp1[sel];
    o2   = exp2[sel];
    n1   = take ? w1 : o1;
    n2   = take ? w2 : o2;
    rises = 0;
    pclk  = 1'b0;
    for (int k = 0; k < 52 * h; k++) begin
      @(negedge clk);
      if (sel == 1) jd_b = sb[k / per];
      else          jd_a = sb[k / per];
      if (drop_slot >= 0 && k == drop_slot * per) begin
        if (sel == 1) scan_b = 1'b0;
        else          scan_a = 1'b0;
      end
      if (rst_slot >= 0 && k == rst_slot * per) begin
        rst_n = 1'b0;
        #1;
        chk("rst_async_j1", (sel == 1) ? j1_b : j1_a, 12'hFFF);
        chk("rst_async_j2", (sel == 1) ? j2_b : j2_a, 12'hFFF);
        chk("rst_async_load", (sel == 1) ? ld_b : ld_a, 1'b1);
        chk("rst_async_clk", (sel == 1) ? ck_b : ck_a, 1'b0);
        model_reset();
        return;
      end
      if (sel == 1) begin
        o_ld = ld_b; o_ck = ck_b; o_dn = dn_b; o_j1 = j1_b; o_j2 = j2_b; other_ld = ld_a;
      end else begin
        o_ld = ld_a; o_ck = ck_a; o_dn = dn_a; o_j1 = j1_a; o_j2 = j2_a; other_ld = ld_b;
      end
      chk("joy_load", o_ld, (k < per) ? 1'b0 : 1'b1);
      chk("joy_clk", o_ck, ((k % per) >= h) ? 1'b1 : 1'b0);
      chk("frame_done", o_dn, (k == 51 * h + 1) ? 1'b1 : 1'b0);
      chk("joystick1", o_j1, (k > 51 * h) ? n1 : o1);
      chk("joystick2", o_j2, (k > 51 * h) ? n2 : o2);
      chk("other_load", other_ld, 1'b1);
      if (o_ck && !pclk) rises++;
      pclk = o_ck;
    end
    chk("clk_rises", rises, 26);
    exp1[sel]   = n1;
    exp2[sel]   = n2;
    prev_m[sel] = sb[25:2];
  endtask

  initial begin
    logic [25:0] p;
    int n;
    rst_n  = 1'b0;
    scan_a = 1'b0;
    scan_b = 1'b0;
    jd_a   = 1'b1;
    jd_b   = 1'b1;
    model_reset();

    repeat (3) @(negedge clk);
    chk("reset_j1_a", j1_a, 12'hFFF);
    chk("reset_j2_a", j2_a, 12'hFFF);
    chk("reset_load_a", ld_a, 1'b1);
    chk("reset_clk_a", ck_a, 1'b0);
    chk("reset_done_a", dn_a, 1'b0);
    chk("reset_j1_b", j1_b, 12'hFFF);
    rst_n = 1'b1;
    idle_check(60);

    scan_a = 1'b1;
    run_frame(0, ONES & ~(26'd1 << 3), -1, -1);
    chk("map_slot3_j1", j1_a, 12'hFBF);
    chk("map_slot3_j2", j2_a, 12'hFFF);
    repeat (4) run_frame(0, 26'($urandom), -1, -1);
    run_frame(0, ONES & ~26'h03FFC00, -1, -1);
    chk("p2_all_low", j2_a, 12'h000);
    run_frame(0, 26'($urandom), -1, 20);
    repeat (2) begin
      @(negedge clk);
      chk("held_rst_j2_a", j2_a, 12'hFFF);
      chk("held_rst_load_a", ld_a, 1'b1);
    end
    rst_n = 1'b1;
    run_frame(0, 26'($urandom), -1, -1);
    run_frame(0, 26'($urandom), 12, -1);
    idle_check(80);

    scan_b = 1'b1;
    run_frame(1, ONES, -1, -1);
    run_frame(1, ONES & ~(26'd1 << 25), -1, -1);
    chk("deb_single_j1", j1_b, 12'hFFF);
    run_frame(1, ONES, -1, -1);
    run_frame(1, ONES & ~(26'd1 << 25), -1, -1);
    run_frame(1, ONES & ~(26'd1 << 25), -1, -1);
    chk("deb_double_j1", j1_b, 12'hF7F);
    repeat (4) begin
      p = 26'($urandom);
      n = $urandom_range(1, 2);
      repeat (n) run_frame(1, p, -1, -1);
    end
    run_frame(1, 26'($urandom), 12, -1);
    idle_check(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
